iter_shifter: RTL and testbench
===============================

Name: iter_shifter

Overview:
- Multi-cycle, parametrised shifter unit for the MIPS datapath. It is the general successor of the fixed left-shift-by-2 offset shifter.
- Performs SLL/SRL/SRA by a variable amount, shifting STEP bits per cycle.
- Sits beside the ALU and serves shift instructions and branch/jump offset scaling.
- Uses a valid/ready handshake on both input and output, so the control unit can stall on it.

Parameters:
- WIDTH, 32, data word width in bits (power of two, >= 8)
- STEP, 1, maximum bits shifted per cycle (power of two, 1..WIDTH)
- SW, $clog2(WIDTH), shift-amount width (derived localparam, not overridable)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request
- in_data  input  WIDTH  operand
- in_shamt  input  SW  shift amount, 0..WIDTH-1
- in_op  input  2  00=SLL, 01=SRL, 10=SRA, 11=ROR (only with optional feature)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  shifted result
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n).
- Reset values: state=IDLE, out_valid=0, out_data=0, busy=0. in_ready=1 once reset is deasserted.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE); combinational from state only.
- IDLE:
  - Accept occurs on an edge with in_valid && in_ready.
  - Registers in_data, in_shamt (as remaining count) and in_op.
  - Next state is SHIFT if in_shamt!=0, else DONE.
- SHIFT: each cycle
  - k = min(STEP, remaining).
  - Shift the data register by k per op; remaining -= k.
  - When remaining becomes 0 on this edge, go to DONE.
- Shift rules:
  - SLL fills zeros at the LSB.
  - SRL fills zeros at the MSB.
  - SRA fills copies of the current bit WIDTH-1. This equals the original sign, which is preserved.
- DONE:
  - out_valid=1 and out_data=result, both held stable until out_ready.
  - On an edge with out_ready=1: state goes to IDLE and out_valid goes to 0.
  - out_data retains its last value after the handshake.
- Latency: out_valid rises 1 + ceil(shamt/STEP) edges after, and including, the accepting edge.
  - shamt=0 gives 1 edge.
  - WIDTH=32, STEP=1, shamt=31 gives 32 edges.
- Throughput: no overlap. Earliest next accept is the edge after the output handshake.
- in_valid, in_data, in_shamt and in_op are ignored outside IDLE.
- A change in inputs while busy must not affect the result.
- out_ready held high in DONE: completes in one cycle.
- out_ready low: stall indefinitely with no data change.
- Reset mid-operation: immediate return to reset values; the in-flight request is discarded, with no output.
- op=11 without the optional feature: treated as a pass-through.
  - Goes directly to DONE; out_data = in_data regardless of shamt.

Optional Feature:
- Macro: ITER_SHIFTER_ROTATE_EN.
- Defined: op=11 is a rotate right. Bits leaving the LSB re-enter at the MSB. Same cycle timing as the other shifts.
- Undefined: op=11 is a pass-through (1-edge latency, data unchanged). No rotate logic is synthesised.

Decomposition:
- Package shifter_pkg holds:
  - op-code localparams OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROR=2'b11
  - FSM state encoding ST_IDLE, ST_SHIFT, ST_DONE
- Sub-module shift_step: combinational one-step shifter with parameters WIDTH and STEP.
  - Inputs: data, k (0..STEP), op. Output: shifted data.
  - Instantiated once by iter_shifter, which holds all sequential logic.

Test Plan:
- Reset, SLL by 2: WIDTH=32, STEP=1, SLL in_data=0x0000_1234, shamt=2. Expect out_data=0x0000_48D0 and out_valid 3 edges after accept; in_ready=0 during SHIFT.
- SRA sign fill: SRA 0x8000_0000, shamt=31, STEP=4. Expect 0xFFFF_FFFF after 1+8=9 edges; SRL of the same operand gives 0x0000_0001.
- Zero shift and pass-through: shamt=0 SLL 0xDEAD_BEEF gives 0xDEAD_BEEF after 1 edge. op=11 without the macro also gives pass-through after 1 edge.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE. out_valid stays 1 and out_data stays stable; in_valid pulses are ignored. out_ready=1 completes the handshake; in_ready=1 the next cycle.
- Reset mid-shift: assert rst_n=0 during SHIFT of shamt=20. Outputs return to 0/IDLE asynchronously; a fresh request after release completes correctly.
- Rotate (macro defined): ROR 0x0000_0001, shamt=1 gives 0x8000_0000. ROR 0x1234_5678, shamt=8 gives 0x7812_3456.

Source files
------------

// File: rtl/iter_shifter_pkg.sv
// Shared definitions for the iterative shifter: op-codes and FSM states.
// Optional feature macro: ITER_SHIFTER_ROTATE_EN (op=11 rotates right when defined).
package shifter_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/iter_shifter_shift_step.sv
// Combinational single-step shifter: moves the word by k (0..STEP) bits.
// Optional feature macro: ITER_SHIFTER_ROTATE_EN adds rotate-right for op=11;
// without it op=11 passes the data through unchanged.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int KW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [KW-1:0]    i_k,
  input  logic [1:0]       i_op,
  output logic [WIDTH-1:0] o_data
);

`ifdef ITER_SHIFTER_ROTATE_EN
  logic [2*WIDTH-1:0] w_dbl;
`endif

  // Select the shift flavour; SRA replicates the current MSB, which is the original sign.
  always_comb begin
    o_data = i_data;
`ifdef ITER_SHIFTER_ROTATE_EN
    w_dbl  = {i_data, i_data} >> i_k;
`endif
    case (i_op)
      OP_SLL:  o_data = i_data << i_k;
      OP_SRL:  o_data = i_data >> i_k;
      OP_SRA:  o_data = $signed(i_data) >>> i_k;
`ifdef ITER_SHIFTER_ROTATE_EN
      OP_ROR:  o_data = w_dbl[WIDTH-1:0];
`endif
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter for the MIPS datapath: SLL/SRL/SRA by a variable
// amount, at most STEP bits per cycle, with valid/ready on both sides.
// Optional feature macro: ITER_SHIFTER_ROTATE_EN (op=11 = rotate right;
// otherwise op=11 is a one-edge pass-through).
module iter_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int SW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int KW = $clog2(STEP + 1);

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_data;
  logic [SW-1:0]    r_rem;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_outData;

  logic             w_accept;
  logic             w_passThru;
  logic             w_remGeStep;
  logic [KW-1:0]    w_k;
  logic [SW-1:0]    w_remNext;
  logic [WIDTH-1:0] w_shifted;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign out_data  = r_outData;
  assign w_accept  = in_valid && (r_state == ST_IDLE);

`ifdef ITER_SHIFTER_ROTATE_EN
  assign w_passThru = 1'b0;
`else
  assign w_passThru = (in_op == OP_ROR);
`endif

  // Step size is STEP until fewer bits remain; the remainder is then finished in one step.
  // When STEP does not fit in SW bits (STEP == WIDTH) the remainder path is always taken.
  always_comb begin
    w_remGeStep = (int'(r_rem) >= STEP);
    w_k         = w_remGeStep ? KW'(STEP) : KW'(r_rem);
    w_remNext   = w_remGeStep ? (r_rem - SW'(STEP)) : '0;
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .i_data (r_data),
    .i_k    (w_k),
    .i_op   (r_op),
    .o_data (w_shifted)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic: zero-length and pass-through requests skip straight to DONE.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_passThru || (in_shamt == '0)) begin
            w_stateNext = ST_DONE;
          end else begin
            w_stateNext = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (w_remNext == '0) begin
          w_stateNext = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_stateNext = ST_IDLE;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Datapath: capture the request, iterate the shift, and latch the result once,
  // so out_data stays stable through back-pressure and after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_rem     <= '0;
      r_op      <= OP_SLL;
      r_outData <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_data <= in_data;
            r_rem  <= in_shamt;
            r_op   <= in_op;
            if (w_passThru || (in_shamt == '0)) begin
              r_outData <= in_data;
            end
          end
        end
        ST_SHIFT: begin
          r_data <= w_shifted;
          r_rem  <= w_remNext;
          if (w_remNext == '0) begin
            r_outData <= w_shifted;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter: two instances (STEP=1 and STEP=4)
// share one request stream; results and latencies are compared against a
// behavioural model. Honours ITER_SHIFTER_ROTATE_EN for op=11 expectations.
module tb_iter_shifter;

  localparam int WIDTH = 32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_ready;

  logic        inReady1, outValid1, busy1;
  logic [31:0] outData1;
  logic        inReady4, outValid4, busy4;
  logic [31:0] outData4;

  int nAsserts;
  int nFails;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    int          shamt;
    int          stall;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[$];

  iter_shifter #(.WIDTH(WIDTH), .STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(inReady1),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(outValid1), .out_ready(out_ready),
    .out_data(outData1), .busy(busy1)
  );

  iter_shifter #(.WIDTH(WIDTH), .STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(inReady4),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(outValid4), .out_ready(out_ready),
    .out_data(outData4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAsserts++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: result of the whole shift in one go.
  function automatic logic [31:0] modelResult(input logic [1:0] op, input logic [31:0] d, input int sh);
    logic [63:0] dbl;
    case (op)
      2'b00: return d << sh;
      2'b01: return d >> sh;
      2'b10: return 32'($signed(d) >>> sh);
      default: begin
`ifdef ITER_SHIFTER_ROTATE_EN
        dbl = {d, d} >> sh;
        return dbl[31:0];
`else
        dbl = '0;
        return d + dbl[31:0];
`endif
      end
    endcase
  endfunction

  function automatic int modelLatency(input logic [1:0] op, input int sh, input int step);
`ifndef ITER_SHIFTER_ROTATE_EN
    if (op == 2'b11) return 1;
`endif
    return 1 + (sh + step - 1) / step;
  endfunction

  // One complete transaction on both instances, with optional back-pressure.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] d, input int sh,
                               input int stall, input logic [31:0] exp);
    int edges;
    int lat1, lat4;
    in_valid  = 1'b1;
    in_op     = op;
    in_data   = d;
    in_shamt  = 5'(sh);
    out_ready = 1'b0;
    stepEdge();
    edges = 1;
    lat1  = outValid1 ? 1 : 0;
    lat4  = outValid4 ? 1 : 0;
    checkOutput("in_ready low after accept", {31'b0, inReady1 | inReady4}, 32'd0);
    checkOutput("busy after accept", {30'b0, busy1, busy4}, 32'd3);
    while (!(outValid1 && outValid4) && edges < 80) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      in_shamt = 5'($urandom_range(0, 31));
      in_op    = 2'($urandom_range(0, 3));
      stepEdge();
      edges++;
      if (lat1 == 0 && outValid1) lat1 = edges;
      if (lat4 == 0 && outValid4) lat4 = edges;
    end
    checkOutput("latency STEP=1", lat1, modelLatency(op, sh, 1));
    checkOutput("latency STEP=4", lat4, modelLatency(op, sh, 4));
    checkOutput("data STEP=1", outData1, exp);
    checkOutput("data STEP=4", outData4, exp);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      stepEdge();
      checkOutput("stall out_valid", {30'b0, outValid1, outValid4}, 32'd3);
      checkOutput("stall data STEP=1", outData1, exp);
      checkOutput("stall data STEP=4", outData4, exp);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stepEdge();
    out_ready = 1'b0;
    checkOutput("out_valid low after handshake", {30'b0, outValid1, outValid4}, 32'd0);
    checkOutput("in_ready after handshake", {30'b0, inReady1, inReady4}, 32'd3);
    checkOutput("data retained", outData1 ^ outData4 ^ exp, exp);
  endtask

  initial begin
    vec_t v;
    logic [1:0]  rop;
    logic [31:0] rdat;
    int          rsh;

    nAsserts  = 0;
    nFails    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    out_ready = 1'b0;

    v = '{2'b00, 32'h0000_1234, 2,  0, 32'h0000_48D0}; vecs.push_back(v);
    v = '{2'b10, 32'h8000_0000, 31, 0, 32'hFFFF_FFFF}; vecs.push_back(v);
    v = '{2'b01, 32'h8000_0000, 31, 0, 32'h0000_0001}; vecs.push_back(v);
    v = '{2'b00, 32'hDEAD_BEEF, 0,  0, 32'hDEAD_BEEF}; vecs.push_back(v);
    v = '{2'b01, 32'hF0F0_F0F0, 4,  5, 32'h0F0F_0F0F}; vecs.push_back(v);
    v = '{2'b10, 32'h4000_0000, 30, 1, 32'h0000_0001}; vecs.push_back(v);
`ifdef ITER_SHIFTER_ROTATE_EN
    v = '{2'b11, 32'h0000_0001, 1,  0, 32'h8000_0000}; vecs.push_back(v);
    v = '{2'b11, 32'h1234_5678, 8,  0, 32'h7812_3456}; vecs.push_back(v);
`else
    v = '{2'b11, 32'hDEAD_BEEF, 7,  0, 32'hDEAD_BEEF}; vecs.push_back(v);
    v = '{2'b11, 32'h1234_5678, 8,  2, 32'h1234_5678}; vecs.push_back(v);
`endif

    #12;
    checkOutput("reset out_valid", {30'b0, outValid1, outValid4}, 32'd0);
    checkOutput("reset out_data", outData1 | outData4, 32'd0);
    checkOutput("reset busy", {30'b0, busy1, busy4}, 32'd0);
    rst_n = 1'b1;
    stepEdge();
    checkOutput("in_ready after reset", {30'b0, inReady1, inReady4}, 32'd3);

    $display("[TB] directed vectors");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].data, vecs[i].shamt, vecs[i].stall, vecs[i].expData);
    end

    $display("[TB] reset during shift");
    in_valid = 1'b1;
    in_op    = 2'b00;
    in_data  = 32'h0000_00FF;
    in_shamt = 5'd20;
    stepEdge();
    in_valid = 1'b0;
    repeat (3) stepEdge();
    checkOutput("busy mid-shift", {30'b0, busy1, busy4}, 32'd3);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", {30'b0, busy1, busy4}, 32'd0);
    checkOutput("async reset out_valid", {30'b0, outValid1, outValid4}, 32'd0);
    checkOutput("async reset out_data", outData1 | outData4, 32'd0);
    stepEdge();
    rst_n = 1'b1;
    stepEdge();
    checkOutput("in_ready after mid reset", {30'b0, inReady1, inReady4}, 32'd3);
    applyStimulus(2'b00, 32'h0000_00FF, 20, 0, 32'h0FF0_0000);

    $display("[TB] random transactions");
    for (int n = 0; n < 40; n++) begin
      rop  = 2'($urandom_range(0, 3));
      rdat = $urandom;
      rsh  = $urandom_range(0, 31);
      applyStimulus(rop, rdat, rsh, $urandom_range(0, 2), modelResult(rop, rdat, rsh));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
